// File: rtl/mem_bus_initiator.sv
// ---------------------------------------------------------------------------
// mem_bus_initiator : command-driven initiator for the picorv32 native memory
//                     bus (single read/write, incrementing burst read, timeout)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_bus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned COUNT_BITS     = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic                  cmd_instr,
  input  logic [31:0]           cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  input  logic [COUNT_BITS-1:0] cmd_count,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic                  rsp_last,
  output logic                  busy,
  output logic                  mem_valid,
  output logic                  mem_instr,
  input  logic                  mem_ready,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [31:0]           mem_rdata
);

  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
      (TIMEOUT_CYCLES > 0) ? WAIT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t                state_q,     state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;
  logic                  rsp_last_q,  rsp_last_d;
  logic                  busy_q,      busy_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  mem_instr_q, mem_instr_d;
  logic [31:0]           mem_addr_q,  mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_wstrb_q, mem_wstrb_d;
  logic [COUNT_BITS-1:0] remaining_q, remaining_d;
  logic                  is_write_q,  is_write_d;
  logic [WAIT_W-1:0]     wait_cnt_q,  wait_cnt_d;
  logic                  expired;

  // Expiry is the last waiting cycle; a simultaneous mem_ready takes priority.
  assign expired = TIMEOUT_EN && (wait_cnt_q == WAIT_LAST);

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    rsp_last_d  = rsp_last_q;
    mem_valid_d = mem_valid_q;
    mem_instr_d = mem_instr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    remaining_d = remaining_q;
    is_write_d  = is_write_q;
    wait_cnt_d  = wait_cnt_q;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          mem_valid_d = 1'b1;
          mem_instr_d = cmd_instr;
          mem_addr_d  = cmd_addr;
          mem_wdata_d = cmd_wdata;
          mem_wstrb_d = cmd_write ? cmd_wstrb : 4'h0;
          remaining_d = cmd_write ? '0 : cmd_count;
          is_write_d  = cmd_write;
          wait_cnt_d  = '0;
          state_d     = REQ;
        end
      end

      REQ: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = is_write_q ? 32'h0 : mem_rdata;
          rsp_error_d = 1'b0;
          rsp_last_d  = (remaining_q == '0);
          state_d     = RSP;
        end else if (expired) begin
          mem_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'h0;
          rsp_error_d = 1'b1;
          rsp_last_d  = 1'b1;
          remaining_d = '0;
          state_d     = RSP;
        end else begin
          wait_cnt_d  = wait_cnt_q + WAIT_W'(1);
        end
      end

      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (rsp_last_q) begin
            cmd_ready_d = 1'b1;
            state_d     = IDLE;
          end else begin
            mem_addr_d  = mem_addr_q + 32'd4;
            remaining_d = remaining_q - COUNT_BITS'(1);
            mem_valid_d = 1'b1;
            wait_cnt_d  = '0;
            state_d     = REQ;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_error_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_instr_q <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wstrb_q <= 4'h0;
      remaining_q <= '0;
      is_write_q  <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      rsp_last_q  <= rsp_last_d;
      busy_q      <= busy_d;
      mem_valid_q <= mem_valid_d;
      mem_instr_q <= mem_instr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      remaining_q <= remaining_d;
      is_write_q  <= is_write_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign rsp_last  = rsp_last_q;
  assign busy      = busy_q;
  assign mem_valid = mem_valid_q;
  assign mem_instr = mem_instr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_initiator.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_initiator : self-checking bench with a bus responder and a
//                        transaction-level model of the expected beats
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_bus_initiator;

  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic        cmd_instr = 1'b0;
  logic [31:0] cmd_addr = 32'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic [3:0]  cmd_wstrb = 4'h0;
  logic [7:0]  cmd_count = 8'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_last;
  logic        busy;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_initiator #(
    .TIMEOUT_CYCLES(TO),
    .COUNT_BITS    (8)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_instr(cmd_instr),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_wstrb(cmd_wstrb),
    .cmd_count(cmd_count),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .rsp_last (rsp_last),
    .busy     (busy),
    .mem_valid(mem_valid),
    .mem_instr(mem_instr),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          write;
    bit          instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [7:0]  count;
    int          lat;       // mem_valid cycles before mem_ready (>= TO never answers)
    int          rstall;    // cycles rsp_ready is withheld per beat
    int          exp_beats;
    bit          exp_err;
    logic [31:0] exp_last_addr;
  } vec_t;

  function automatic logic [31:0] mem_func(input logic [31:0] a);
    if (a == 32'h3000_0000) return 32'h0123_4567;
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one command and plays the responder, checking every beat against
  // the transaction model: beat i targets addr+4i, a beat that is never
  // answered within TO cycles ends the command with an error beat.
  task automatic run_cmd(input vec_t v, output int beats, output bit saw_err,
                         output logic [31:0] last_addr);
    int          guard;
    bit          last;
    bit          exp_err;
    bit          exp_last;
    int          nb_exp;
    logic [31:0] a;
    logic [31:0] exp_rd;
    logic [3:0]  exp_strb;
    beats = 0;
    saw_err = 1'b0;
    last_addr = 32'h0;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (cmd_ready !== 1'b1) begin
      check("cmd_ready_wait", {31'h0, cmd_ready}, 32'h1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_instr = v.instr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_wstrb = v.wstrb;
    cmd_count = v.count;
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd_write = ~v.write;
    cmd_instr = ~v.instr;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_wstrb = 4'($urandom);
    cmd_count = 8'($urandom);

    exp_err  = (v.lat >= TO);
    nb_exp   = v.write ? 1 : int'(v.count) + 1;
    exp_strb = v.write ? v.wstrb : 4'h0;
    last = 1'b0;
    for (int i = 0; !last && i < 300; i++) begin
      a = v.addr + 32'(4 * i);
      last_addr = mem_addr;
      for (int k = 0; k <= TO; k++) begin
        check("req_valid", {31'h0, mem_valid}, 32'h1);
        check("req_addr", mem_addr, a);
        check("req_ctl", {25'h0, mem_wstrb, mem_instr, cmd_ready, busy},
              {25'h0, exp_strb, v.instr, 1'b0, 1'b1});
        if (v.write) check("req_wdata", mem_wdata, v.wdata);
        if (k == v.lat) begin
          mem_ready = 1'b1;
          mem_rdata = mem_func(a);
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
        end
        @(negedge clock);
        mem_ready = 1'b0;
        if (k == v.lat || k == TO - 1) break;
      end
      exp_last = exp_err || (i == nb_exp - 1);
      exp_rd   = (v.write || exp_err) ? 32'h0 : mem_func(a);
      check("rsp_flags", {28'h0, rsp_valid, mem_valid, rsp_error, rsp_last},
            {28'h0, 1'b1, 1'b0, exp_err, exp_last});
      check("rsp_rdata", rsp_rdata, exp_rd);
      beats++;
      saw_err = saw_err | rsp_error;
      last = rsp_last;
      for (int s = 0; s < v.rstall; s++) begin
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        @(negedge clock);
        check("rsp_hold", {28'h0, rsp_valid, mem_valid, rsp_error, rsp_last},
              {28'h0, 1'b1, 1'b0, exp_err, exp_last});
        check("rsp_hold_rdata", rsp_rdata, exp_rd);
      end
      mem_ready = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clock);
      rsp_ready = 1'b0;
    end
    check("idle_after", {28'h0, cmd_ready, busy, mem_valid, rsp_valid}, 32'h8);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int          beats;
    bit          err;
    logic [31:0] la;
    run_cmd(v, beats, err, la);
    check({name, "_beats"}, 32'(beats), 32'(v.exp_beats));
    check({name, "_err"}, {31'h0, err}, {31'h0, v.exp_err});
    check({name, "_last_addr"}, la, v.exp_last_addr);
  endtask

  vec_t tbl[6];
  vec_t rv;

  initial begin
    //       wr instr addr           wdata          wstrb cnt lat rst beats err last_addr
    tbl[0] = '{0, 0, 32'h3000_0000, 32'h0,         4'h0, 0,  1,  0,  1,  0, 32'h3000_0000};
    tbl[1] = '{1, 0, 32'h3000_0004, 32'hA5,        4'hF, 5,  3,  1,  1,  0, 32'h3000_0004};
    tbl[2] = '{0, 1, 32'h0000_0010, 32'h0,         4'h0, 3,  1,  5,  4,  0, 32'h0000_001C};
    tbl[3] = '{0, 0, 32'h0000_2000, 32'h0,         4'h0, 2,  20, 2,  1,  1, 32'h0000_2000};
    tbl[4] = '{0, 0, 32'hFFFF_FFFC, 32'h0,         4'h0, 1,  7,  0,  2,  0, 32'h0000_0000};
    tbl[5] = '{1, 1, 32'h0000_0040, 32'hDEAD_BEEF, 4'h0, 0,  0,  0,  1,  0, 32'h0000_0040};

    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_ctl", {25'h0, cmd_ready, rsp_valid, rsp_error, rsp_last, busy, mem_valid, mem_instr},
          32'h0);
    check("reset_bus", mem_addr | mem_wdata | {28'h0, mem_wstrb} | rsp_rdata, 32'h0);
    reset = 1'b0;
    @(negedge clock);
    check("cmd_ready_after_reset", {31'h0, cmd_ready}, 32'h1);

    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    for (int i = 0; i < 25; i++) begin
      rv.write  = 1'($urandom_range(0, 1));
      rv.instr  = 1'($urandom_range(0, 1));
      rv.addr   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      rv.wdata  = $urandom;
      rv.wstrb  = 4'($urandom);
      rv.count  = 8'($urandom_range(0, 5));
      rv.lat    = $urandom_range(0, 9);
      rv.rstall = $urandom_range(0, 3);
      rv.exp_err   = (rv.lat >= TO);
      rv.exp_beats = rv.exp_err ? 1 : (rv.write ? 1 : int'(rv.count) + 1);
      rv.exp_last_addr = rv.addr + 32'(4 * (rv.exp_beats - 1));
      run_vec($sformatf("rnd%0d", i), rv);
    end

    // Reset while a burst is outstanding: no response, clean restart.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_0100;
    cmd_count = 8'd3;
    @(negedge clock);
    cmd_valid = 1'b0;
    check("midburst_req", {31'h0, mem_valid}, 32'h1);
    reset = 1'b1;
    @(negedge clock);
    check("midburst_reset", {27'h0, mem_valid, rsp_valid, busy, cmd_ready, rsp_last}, 32'h0);
    check("midburst_reset_addr", mem_addr, 32'h0);
    reset = 1'b0;
    @(negedge clock);
    check("midburst_ready", {29'h0, cmd_ready, mem_valid, rsp_valid}, 32'h4);
    run_vec("post_reset", tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
